// File: rtl/regbus_pkg.sv
// regbus_pkg: op/state encodings and default widths shared by the register-bus master
package regbus_pkg;
    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 16;
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_SETBITS = 2'b10, OP_CLEAR_ALL = 2'b11} op_e;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_CLR, S_RESP} state_e;
endpackage

// File: rtl/regbus_master.sv
// regbus_master: sequences READ/WRITE/SETBITS/CLEAR_ALL commands onto a single-cycle register bus
module regbus_master
    import regbus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              bus_sel,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic [7:0]        op_count
);
    state_e            state;
    op_e               op;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] mask;

    assign cmd_ready = rst && state == S_IDLE;
    assign busy      = state != S_IDLE;
    assign rsp_valid = state == S_RESP;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            op        <= OP_READ;
            mask      <= '0;
            idx       <= '0;
            bus_sel   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_data  <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op        <= op_e'(cmd_op);
                    mask      <= cmd_data;
                    idx       <= '0;
                    rsp_data  <= '0;
                    bus_sel   <= 1'b1;
                    // WRITE and CLEAR_ALL open with a write cycle, READ and SETBITS with a read
                    bus_wr    <= cmd_op[0];
                    bus_addr  <= cmd_op == OP_CLEAR_ALL ? '0 : cmd_addr;
                    bus_wdata <= cmd_op == OP_WRITE ? cmd_data : '0;
                    state     <= cmd_op == OP_WRITE ? S_WR : cmd_op == OP_CLEAR_ALL ? S_CLR : S_RD;
                end
                S_RD: begin
                    rsp_data  <= bus_rdata;
                    bus_sel   <= op == OP_SETBITS;
                    bus_wr    <= op == OP_SETBITS;
                    bus_addr  <= op == OP_SETBITS ? bus_addr : '0;
                    bus_wdata <= op == OP_SETBITS ? bus_rdata | mask : '0;
                    state     <= op == OP_SETBITS ? S_WR : S_RESP;
                end
                S_WR: begin
                    bus_sel   <= 1'b0;
                    bus_wr    <= 1'b0;
                    bus_addr  <= '0;
                    bus_wdata <= '0;
                    state     <= S_RESP;
                end
                S_CLR: if (idx == '1) begin
                    bus_sel   <= 1'b0;
                    bus_wr    <= 1'b0;
                    bus_addr  <= '0;
                    bus_wdata <= '0;
                    state     <= S_RESP;
                end else begin
                    idx       <= idx + ADDR_W'(1);
                    bus_addr  <= idx + ADDR_W'(1);
                end
                S_RESP: if (rsp_ready) begin
                    rsp_data  <= '0;
                    op_count  <= op_count + 8'd1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regbus_master.sv
// tb_regbus_master: randomized and directed checks of regbus_master against a register-file reference model
module tb_regbus_master;
    localparam int AW = 2;
    localparam int DW = 16;
    localparam int NR = 4;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } bus_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          bus_sel;
    logic          bus_wr;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          busy;
    logic [7:0]    op_count;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] gold [NR];
    bus_t          seen [$];
    bus_t          want [$];
    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_count = '0;
    int            lat_tab [4] = '{2, 2, 3, 5};

    always #5 clk = ~clk;

    regbus_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .bus_sel(bus_sel), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .busy(busy), .op_count(op_count)
    );

    // register-file slave
    always @(posedge clk) if (bus_sel && bus_wr) regs[bus_addr] <= bus_wdata;
    assign bus_rdata = (bus_sel && !bus_wr) ? regs[bus_addr] : '0;

    always @(negedge clk) if (rst) begin
        if (bus_sel) seen.push_back({bus_wr, bus_addr, bus_wr ? bus_wdata : 16'h0});
        else begin
            checks++;
            if (bus_wr !== 1'b0 || bus_addr !== '0 || bus_wdata !== '0) begin
                errors++;
                $display("FAIL idle_bus got wr=%b addr=%0d wdata=%h want all 0", bus_wr, bus_addr, bus_wdata);
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
        logic [DW-1:0] exp_rsp;
        logic [DW-1:0] held;
        int lat;
        bit ok;
        want.delete();
        case (op)
            2'd0: begin want.push_back({1'b0, a, 16'h0}); exp_rsp = gold[a]; end
            2'd1: begin want.push_back({1'b1, a, d}); gold[a] = d; exp_rsp = '0; end
            2'd2: begin
                want.push_back({1'b0, a, 16'h0});
                want.push_back({1'b1, a, gold[a] | d});
                exp_rsp = gold[a];
                gold[a] = gold[a] | d;
            end
            default: begin
                for (int i = 0; i < NR; i++) begin
                    want.push_back({1'b1, 2'(i), 16'h0});
                    gold[i] = '0;
                end
                exp_rsp = '0;
            end
        endcase
        @(negedge clk);
        seen.delete();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_idle got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_data = DW'($urandom);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != lat_tab[op]) begin errors++; $display("FAIL latency op=%0d got %0d want %0d", op, lat, lat_tab[op]); end
        checks++;
        if (rsp_data !== exp_rsp) begin errors++; $display("FAIL rsp_data op=%0d addr=%0d got %h want %h", op, a, rsp_data, exp_rsp); end
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_data = DW'($urandom);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 || busy !== 1'b1 || op_count !== exp_count) begin
                errors++;
                $display("FAIL rsp_hold got valid=%b data=%h ready=%b busy=%b count=%0d want 1 %h 0 1 %0d",
                         rsp_valid, rsp_data, cmd_ready, busy, op_count, held, exp_count);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_count++;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || op_count !== exp_count) begin
            errors++;
            $display("FAIL after_handshake got valid=%b busy=%b ready=%b count=%0d want 0 0 1 %0d",
                     rsp_valid, busy, cmd_ready, op_count, exp_count);
        end
        @(negedge clk);
        ok = seen.size() == want.size();
        if (ok) foreach (want[i]) if (seen[i] !== want[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bus_trace op=%0d got %0d cycles first=%h want %0d cycles first=%h",
                     op, seen.size(), seen.size() ? seen[0] : bus_t'(0), want.size(), want[0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== '0 || busy !== 1'b0 || op_count !== 8'd0 ||
            bus_sel !== 1'b0 || bus_wr !== 1'b0 || bus_addr !== '0 || bus_wdata !== '0) begin
            errors++;
            $display("FAIL reset_state got ready=%b valid=%b data=%h busy=%b count=%0d sel=%b wr=%b want all 0",
                     cmd_ready, rsp_valid, rsp_data, busy, op_count, bus_sel, bus_wr);
        end
        cmd_valid = 1'b0; rst = 1'b1;
        exp_count = '0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset got ready=%b busy=%b want 1 0", cmd_ready, busy); end
    endtask

    task automatic test_directed();
        for (int i = 0; i < NR; i++) do_cmd(2'd1, AW'(i), DW'($urandom) | 16'h0100, 0);
        do_cmd(2'd1, 2'd2, 16'hBEEF, 0);
        do_cmd(2'd1, 2'd1, 16'h00F0, 0);
        do_cmd(2'd2, 2'd1, 16'h0F01, 0);
        do_cmd(2'd0, 2'd1, 16'h0000, 0);
        checks++;
        if (gold[1] !== 16'h0FF1) begin errors++; $display("FAIL setbits_model got %h want 0ff1", gold[1]); end
        do_cmd(2'd3, 2'd0, 16'hFFFF, 0);
        for (int i = 0; i < NR; i++) do_cmd(2'd0, AW'(i), 16'h0, 0);
    endtask

    task automatic test_backpressure();
        do_cmd(2'd1, 2'd3, 16'h1234, 5);
        do_cmd(2'd0, 2'd3, 16'h0, 5);
        do_cmd(2'd2, 2'd3, 16'h8001, 5);
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < NR; i++) do_cmd(2'd1, AW'(i), 16'h1111 * DW'(i + 1), 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus_sel !== 1'b1 || bus_addr !== 2'd1) begin errors++; $display("FAIL clr_index got sel=%b addr=%0d want 1 1", bus_sel, bus_addr); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus_sel !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0) begin
            errors++;
            $display("FAIL abort got sel=%b valid=%b busy=%b count=%0d want 0 0 0 0", bus_sel, rsp_valid, busy, op_count);
        end
        gold[0] = '0; gold[1] = '0; exp_count = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || bus_sel !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet got valid=%b busy=%b sel=%b want 0 0 0", rsp_valid, busy, bus_sel);
            end
        end
        for (int i = 0; i < NR; i++) do_cmd(2'd0, AW'(i), 16'h0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < NR; i++) do_cmd(2'd1, AW'(i), DW'($urandom), 0);
        for (int n = 0; n < 40; n++)
            do_cmd(2'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 3)));
    endtask

    task automatic test_wrap();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        exp_count = '0;
        for (int n = 0; n < 255; n++) do_cmd(2'd1, AW'(n), DW'(n), 0);
        checks++;
        if (op_count !== 8'd255) begin errors++; $display("FAIL count_255 got %0d want 255", op_count); end
        do_cmd(2'd1, 2'd0, 16'hA5A5, 0);
        checks++;
        if (op_count !== 8'd0) begin errors++; $display("FAIL count_wrap got %0d want 0", op_count); end
    endtask

    initial begin
        foreach (gold[i]) gold[i] = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_clear();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
